data_mem: RTL and testbench

- Byte-addressable, single-port data memory for the RV32 core's load/store path.
- Reads are combinational; writes are synchronous.
- Supports byte, halfword and word accesses, with optional sign extension on loads.
- Flags misaligned accesses; does not trap itself. The core's exception logic consumes alignment_error.

---
 rtl/config_pkg.sv | 6 +
 rtl/mem_pkg.sv | 12 +
 rtl/mem_load_align.sv | 41 ++++
 rtl/data_mem.sv | 84 ++++++++
 tb/tb_data_mem.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/config_pkg.sv
// Build-time configuration shared by the memory subsystem.
package config_pkg;

    localparam int unsigned MemSize = 32'h0000_1000;

endpackage : config_pkg

// File: rtl/mem_pkg.sv
// Access-size encoding for the load/store path; matches RV funct3[1:0].
package mem_pkg;

    typedef enum logic [1:0] {
        BYTE     = 2'd0,
        HALFWORD = 2'd1,
        WORD     = 2'd2
    } mem_width_t;

    localparam int unsigned WordWidth = 32;

endpackage : mem_pkg

// File: rtl/mem_load_align.sv
// Load lane select, sign/zero extension and misalignment detection.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [WordWidth-1:0] i_word,
    input  logic [1:0]           i_addr_lo,
    input  mem_width_t           i_width,
    input  logic                 i_sign_extend,
    output logic [WordWidth-1:0] o_data_c,
    output logic                 o_align_err_c
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[8*i_addr_lo +: 8];
    assign w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        o_data_c      = '0;
        o_align_err_c = 1'b0;
        case (i_width)
            BYTE: begin
                o_data_c = {{24{i_sign_extend & w_byte[7]}}, w_byte};
            end
            HALFWORD: begin
                o_data_c      = {{16{i_sign_extend & w_half[15]}}, w_half};
                o_align_err_c = i_addr_lo[0];
            end
            WORD: begin
                o_data_c      = i_word;
                o_align_err_c = (i_addr_lo != 2'b00);
            end
            default: begin
                // Reserved encoding: no data, always flagged.
                o_align_err_c = 1'b1;
            end
        endcase
    end

endmodule : mem_load_align

// File: rtl/data_mem.sv
// Byte-addressable RV32 data memory: combinational loads, synchronous byte-masked stores.
module data_mem
    import mem_pkg::*;
#(
    parameter  int unsigned MemSize      = config_pkg::MemSize,
    localparam int unsigned MemAddrWidth = $clog2(MemSize)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    write_enable,
    input  mem_width_t              width,
    input  logic                    sign_extend,
    input  logic [MemAddrWidth-1:0] address,
    input  logic [WordWidth-1:0]    data_in,
    output logic [WordWidth-1:0]    data_out,
    output logic                    alignment_error
);

    localparam int unsigned MemWords     = MemSize / 4;
    localparam int unsigned WordIdxWidth = MemAddrWidth - 2;

    // Power-on image; contents survive reset.
    logic [WordWidth-1:0] r_mem [MemWords] = '{
        0:       32'h1234_5678,
        1:       32'h0000_1111,
        2:       32'h1111_0000,
        3:       32'hB0A0_9080,
        default: 32'h0000_0000
    };

    logic [WordIdxWidth-1:0] w_word_idx;
    logic [1:0]              w_lane;
    logic [WordWidth-1:0]    w_rd_word;
    logic [3:0]              w_be;
    logic [WordWidth-1:0]    w_wdata;

    assign w_word_idx = address[MemAddrWidth-1:2];
    assign w_lane     = address[1:0];
    assign w_rd_word  = r_mem[w_word_idx];

    // Byte enables and lane-replicated store data, aligned down to the access size.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = '0;
        case (width)
            BYTE: begin
                w_be    = 4'b0001 << w_lane;
                w_wdata = {4{data_in[7:0]}};
            end
            HALFWORD: begin
                w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{data_in[15:0]}};
            end
            WORD: begin
                w_be    = 4'b1111;
                w_wdata = data_in;
            end
            default: begin
                w_be    = 4'b0000;
                w_wdata = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset && write_enable) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_word_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    mem_load_align u_load_align (
        .i_word        (w_rd_word),
        .i_addr_lo     (w_lane),
        .i_width       (width),
        .i_sign_extend (sign_extend),
        .o_data_c      (data_out),
        .o_align_err_c (alignment_error)
    );

endmodule : data_mem

// File: tb/tb_data_mem.sv
// Directed self-checking bench for data_mem loads, stores, alignment and reset gating.
module tb_data_mem;
    import mem_pkg::*;

    localparam int unsigned AW = 12;

    logic          clk;
    logic          reset;
    logic          write_enable;
    mem_width_t    width;
    logic          sign_extend;
    logic [AW-1:0] address;
    logic [31:0]   data_in;
    logic [31:0]   data_out;
    logic          alignment_error;

    int n_tests;
    int n_fail;

    data_mem dut (
        .clk             (clk),
        .reset           (reset),
        .write_enable    (write_enable),
        .width           (width),
        .sign_extend     (sign_extend),
        .address         (address),
        .data_in         (data_in),
        .data_out        (data_out),
        .alignment_error (alignment_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_read(input string tag, input mem_width_t w, input int a, input logic sext,
                           input logic [31:0] exp_data, input logic exp_err);
        @(negedge clk);
        write_enable = 1'b0;
        width        = w;
        address      = AW'(a);
        sign_extend  = sext;
        #1;
        check({tag, "_data"}, data_out, exp_data);
        check({tag, "_err"}, 32'(alignment_error), 32'(exp_err));
    endtask

    // Alignment flag is checked while the store is presented, before the edge.
    task automatic do_write(input string tag, input mem_width_t w, input int a,
                            input logic [31:0] d, input logic exp_err);
        @(negedge clk);
        width        = w;
        address      = AW'(a);
        data_in      = d;
        write_enable = 1'b1;
        #1;
        check({tag, "_err"}, 32'(alignment_error), 32'(exp_err));
        @(posedge clk);
        #1;
        write_enable = 1'b0;
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        reset        = 1'b0;
        write_enable = 1'b0;
        width        = WORD;
        sign_extend  = 1'b0;
        address      = '0;
        data_in      = '0;

        // Image is readable while reset is held.
        repeat (2) @(posedge clk);
        do_read("rst_w0", WORD, 0, 1'b0, 32'h1234_5678, 1'b0);
        reset = 1'b1;

        do_read("init_w0", WORD, 0, 1'b0, 32'h1234_5678, 1'b0);
        do_read("init_w4", WORD, 4, 1'b0, 32'h0000_1111, 1'b0);
        do_read("init_w8", WORD, 8, 1'b0, 32'h1111_0000, 1'b0);

        do_read("b0_s", BYTE, 0, 1'b1, 32'h0000_0078, 1'b0);
        do_read("b1_s", BYTE, 1, 1'b1, 32'h0000_0056, 1'b0);
        do_read("b2_s", BYTE, 2, 1'b1, 32'h0000_0034, 1'b0);
        do_read("b3_s", BYTE, 3, 1'b1, 32'h0000_0012, 1'b0);
        do_read("b12_z", BYTE, 12, 1'b0, 32'h0000_0080, 1'b0);
        do_read("b12_s", BYTE, 12, 1'b1, 32'hFFFF_FF80, 1'b0);
        do_read("b13_s", BYTE, 13, 1'b1, 32'hFFFF_FF90, 1'b0);
        do_read("b14_s", BYTE, 14, 1'b1, 32'hFFFF_FFA0, 1'b0);
        do_read("b15_s", BYTE, 15, 1'b1, 32'hFFFF_FFB0, 1'b0);

        do_read("h2_z", HALFWORD, 2, 1'b0, 32'h0000_1234, 1'b0);
        do_read("h14_s", HALFWORD, 14, 1'b1, 32'hFFFF_B0A0, 1'b0);
        do_read("h14_z", HALFWORD, 14, 1'b0, 32'h0000_B0A0, 1'b0);
        do_read("h13_s", HALFWORD, 13, 1'b1, 32'hFFFF_9080, 1'b1);

        do_read("w13", WORD, 13, 1'b0, 32'hB0A0_9080, 1'b1);
        do_read("w14", WORD, 14, 1'b0, 32'hB0A0_9080, 1'b1);
        do_read("w15", WORD, 15, 1'b1, 32'hB0A0_9080, 1'b1);

        do_read("rsv_rd", mem_width_t'(2'd3), 0, 1'b0, 32'h0000_0000, 1'b1);
        do_write("rsv_wr", mem_width_t'(2'd3), 0, 32'hFFFF_FFFF, 1'b1);
        do_read("rsv_keep", WORD, 0, 1'b0, 32'h1234_5678, 1'b0);

        do_write("sb0", BYTE, 0, 32'hAAAA_AA77, 1'b0);
        do_write("sb1", BYTE, 1, 32'h0000_0066, 1'b0);
        do_write("sb2", BYTE, 2, 32'h0000_0055, 1'b0);
        do_write("sb3", BYTE, 3, 32'h0000_0044, 1'b0);
        do_write("sb7", BYTE, 7, 32'h0000_0022, 1'b0);
        do_read("sb_w0", WORD, 0, 1'b0, 32'h4455_6677, 1'b0);
        do_read("sb_w4", WORD, 4, 1'b0, 32'h2200_1111, 1'b0);

        do_write("sh8", HALFWORD, 8, 32'h0000_AA33, 1'b0);
        do_write("sh10", HALFWORD, 10, 32'h0000_BB44, 1'b0);
        do_read("sh_w8", WORD, 8, 1'b0, 32'hBB44_AA33, 1'b0);
        do_write("sh25", HALFWORD, 25, 32'h1234_5566, 1'b1);
        do_read("sh_w24", WORD, 24, 1'b0, 32'h0000_5566, 1'b0);

        do_write("sw21", WORD, 21, 32'hFFEE_DDCC, 1'b1);
        do_read("sw_w20", WORD, 20, 1'b0, 32'hFFEE_DDCC, 1'b0);

        reset = 1'b0;
        do_write("rst_sw16", WORD, 16, 32'hDEAD_BEEF, 1'b0);
        do_read("rst_w16", WORD, 16, 1'b0, 32'h0000_0000, 1'b0);
        reset = 1'b1;
        do_write("sw16", WORD, 16, 32'hDEAD_BEEF, 1'b0);
        do_read("w16", WORD, 16, 1'b0, 32'hDEAD_BEEF, 1'b0);
        do_read("w16_b3", BYTE, 19, 1'b1, 32'hFFFF_FFDE, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_data_mem
